regfile_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage register file and HI/LO pair.
- Provides NRD combinational read ports with optional write-through bypass, one write port, HI/LO with independent write enables and bypass, and a per-register pending-write scoreboard for hazard detection.
- Sits in the ID stage. The issue logic marks destinations busy; writeback clears them.
- A flush input clears all pending state on pipeline redirect.

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with HI/LO pair and a per-register pending-write
// scoreboard. Reads, write-through bypass and busy lookups are combinational.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = $clog2(NREG),
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    input  logic                  hi_we,
    input  logic [DATA_W-1:0]     hi_wdata,
    input  logic                  lo_we,
    input  logic [DATA_W-1:0]     lo_wdata,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              wr_ok;
    logic              iss_ok;

    // Register 0 is hard-wired: writes and issues to it are discarded here.
    assign wr_ok  = wr_en && (wr_addr != '0);
    assign iss_ok = iss_en && (iss_addr != '0) && !flush;

    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = cnt;
        if (flush) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (wr_ok)
                busy_nxt[wr_addr] = 1'b0;
            if (iss_ok)
                busy_nxt[iss_addr] = 1'b1;
            // Count only real transitions; a same-register set/clear nets to a set.
            if (iss_ok && !busy[iss_addr])
                cnt_nxt = cnt_nxt + CNT_ONE;
            if (wr_ok && busy[wr_addr] && !(iss_ok && (iss_addr == wr_addr)))
                cnt_nxt = cnt_nxt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
            busy <= '0;
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            if (hi_we)
                hi_q <= hi_wdata;
            if (lo_we)
                lo_q <= lo_wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              fwd;
        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign fwd = (BYPASS != 0) && wr_ok && (wr_addr == a);
        assign rd_data[i*DATA_W +: DATA_W] = fwd ? wr_data : ((a == '0) ? '0 : regs[a]);
        assign rd_busy[i] = busy[a] && !fwd;
    end

    assign hi       = ((BYPASS != 0) && hi_we) ? hi_wdata : hi_q;
    assign lo       = ((BYPASS != 0) && lo_we) ? lo_wdata : lo_q;
    assign busy_cnt = cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing 2-port instance and a
// non-bypassing 3-port instance, checked against a queue of expected values.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic            wr_en, iss_en, flush, hi_we, lo_we;
    logic [AW-1:0]   wr_addr, iss_addr;
    logic [DW-1:0]   wr_data, hi_wdata, lo_wdata, hi, lo;
    logic [AW:0]     busy_cnt;

    logic [3*AW-1:0] b_rd_addr;
    logic [3*DW-1:0] b_rd_data;
    logic [2:0]      b_rd_busy;
    logic            b_wr_en, b_iss_en, b_flush, b_hi_we, b_lo_we;
    logic [AW-1:0]   b_wr_addr, b_iss_addr;
    logic [DW-1:0]   b_wr_data, b_hi_wdata, b_lo_wdata, b_hi, b_lo;
    logic [AW:0]     b_busy_cnt;

    regfile_scoreboard #(.DATA_W(DW), .NREG(32), .NRD(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
        .hi(hi), .lo(lo), .busy_cnt(busy_cnt)
    );

    regfile_scoreboard #(.DATA_W(DW), .NREG(32), .NRD(3), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .flush(b_flush), .hi_we(b_hi_we), .hi_wdata(b_hi_wdata), .lo_we(b_lo_we), .lo_wdata(b_lo_wdata),
        .hi(b_hi), .lo(b_lo), .busy_cnt(b_busy_cnt)
    );

    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic expect_v(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h required a queued expectation", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        hi_we = 1'b0; hi_wdata = '0; lo_we = 1'b0; lo_wdata = '0;
        b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 1'b0; b_iss_addr = '0; b_flush = 1'b0;
        b_hi_we = 1'b0; b_hi_wdata = '0; b_lo_we = 1'b0; b_lo_wdata = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        // Reset cycles with activity that must be ignored
        repeat (2) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
            iss_en = 1'b1; iss_addr = 5'd3; hi_we = 1'b1; hi_wdata = 32'h5555_5555;
        end

        @(negedge clk); idle(); rst_n = 1'b1;
        rd_addr = {5'd5, 5'd3};
        expect_v("reset_rd0", 64'h0); expect_v("reset_rd1", 64'h0);
        expect_v("reset_busy", 64'h0); expect_v("reset_hi", 64'h0);
        expect_v("reset_lo", 64'h0); expect_v("reset_cnt", 64'h0);
        expect_v("reset_cnt_nb", 64'h0);
        #1;
        check_v(64'(rd_data[31:0])); check_v(64'(rd_data[63:32]));
        check_v(64'(rd_busy)); check_v(64'(hi)); check_v(64'(lo));
        check_v(64'(busy_cnt)); check_v(64'(b_busy_cnt));

        @(negedge clk); idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd7};
        expect_v("bypass_rd0", 64'hDEAD_BEEF); expect_v("bypass_rd1_r0", 64'h0);
        #1; check_v(64'(rd_data[31:0])); check_v(64'(rd_data[63:32]));

        @(negedge clk); idle(); rd_addr = {5'd0, 5'd7};
        expect_v("stored_rd0", 64'hDEAD_BEEF);
        #1; check_v(64'(rd_data[31:0]));

        @(negedge clk); idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd7, 5'd0};
        expect_v("r0_no_bypass", 64'h0); expect_v("r7_other_port", 64'hDEAD_BEEF);
        #1; check_v(64'(rd_data[31:0])); check_v(64'(rd_data[63:32]));

        @(negedge clk); idle(); rd_addr = {5'd0, 5'd0};
        expect_v("r0_after_write", 64'h0);
        #1; check_v(64'(rd_data[31:0]));

        // Scoreboard lifecycle on reg 3
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        expect_v("iss3_busy_same_cycle", 64'h0); expect_v("iss3_cnt_same_cycle", 64'h0);
        #1; check_v(64'(rd_busy)); check_v(64'(busy_cnt));

        @(negedge clk); idle(); rd_addr = {5'd0, 5'd3};
        expect_v("iss3_busy", 64'h1); expect_v("iss3_cnt", 64'h1);
        #1; check_v(64'(rd_busy)); check_v(64'(busy_cnt));

        @(negedge clk); idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; rd_addr = {5'd3, 5'd3};
        expect_v("wb3_busy_bypass", 64'h0); expect_v("wb3_data", {32'h33, 32'h33});
        expect_v("wb3_cnt_before_edge", 64'h1);
        #1; check_v(64'(rd_busy)); check_v(rd_data); check_v(64'(busy_cnt));

        @(negedge clk); idle(); rd_addr = {5'd3, 5'd3};
        expect_v("wb3_cnt", 64'h0); expect_v("wb3_busy_after", 64'h0);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy));

        // Simultaneous set/clear on reg 4, re-issue, issue to 0, non-busy writeback
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd4;
        @(negedge clk); idle();
        iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        rd_addr = {5'd0, 5'd4};
        expect_v("setclr4_cnt_pre", 64'h1); expect_v("setclr4_busy_bypass", 64'h0);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy));

        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd4; rd_addr = {5'd0, 5'd4};
        expect_v("setclr4_cnt", 64'h1); expect_v("setclr4_busy", 64'h1);
        expect_v("setclr4_data", 64'h44);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy)); check_v(64'(rd_data[31:0]));

        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC0C0;
        expect_v("reissue4_cnt", 64'h1);
        #1; check_v(64'(busy_cnt));

        @(negedge clk); idle(); rd_addr = {5'd12, 5'd0};
        expect_v("iss0_wb12_cnt", 64'h1); expect_v("r0_busy", 64'h0);
        expect_v("wb12_data", 64'hC0C0);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy)); check_v(64'(rd_data[63:32]));

        // Build busy set {1,2,9} while retiring 4, then flush with a squashed issue
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd1;
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd2;
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444;
        @(negedge clk); idle(); rd_addr = {5'd9, 5'd1};
        expect_v("pre_flush_cnt", 64'h3); expect_v("pre_flush_busy", 64'h3);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy));

        @(negedge clk); idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
        @(negedge clk); idle(); rd_addr = {5'd9, 5'd10};
        expect_v("flush_cnt", 64'h0); expect_v("flush_busy", 64'h0);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy));

        // HI/LO
        @(negedge clk); idle();
        hi_we = 1'b1; hi_wdata = 32'hAAAA_0000; lo_we = 1'b1; lo_wdata = 32'h0000_BBBB;
        expect_v("hi_bypass", 64'hAAAA_0000); expect_v("lo_bypass", 64'h0000_BBBB);
        #1; check_v(64'(hi)); check_v(64'(lo));

        @(negedge clk); idle();
        expect_v("hi_hold", 64'hAAAA_0000); expect_v("lo_hold", 64'h0000_BBBB);
        #1; check_v(64'(hi)); check_v(64'(lo));

        @(negedge clk); idle(); hi_we = 1'b1; hi_wdata = 32'h1234_5678;
        @(negedge clk); idle();
        expect_v("hi_only", 64'h1234_5678); expect_v("lo_untouched", 64'h0000_BBBB);
        #1; check_v(64'(hi)); check_v(64'(lo));

        // Reset while two registers are busy and a write is in flight
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd5;
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd6;
        @(negedge clk); idle();
        expect_v("pre_rst_cnt", 64'h2);
        #1; check_v(64'(busy_cnt));
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd8;
        @(negedge clk); idle(); rst_n = 1'b1; rd_addr = {5'd6, 5'd5};
        expect_v("rst_mid_cnt", 64'h0); expect_v("rst_mid_busy", 64'h0);
        expect_v("rst_mid_data", 64'h0); expect_v("rst_mid_hi", 64'h0); expect_v("rst_mid_lo", 64'h0);
        #1; check_v(64'(busy_cnt)); check_v(64'(rd_busy)); check_v(rd_data);
        check_v(64'(hi)); check_v(64'(lo));
        rd_addr = {5'd8, 5'd7};
        expect_v("rst_mid_r7", 64'h0); expect_v("rst_mid_busy8", 64'h0);
        #1; check_v(64'(rd_data[31:0])); check_v(64'(rd_busy));

        // Non-bypassing 3-port instance
        @(negedge clk); idle(); b_iss_en = 1'b1; b_iss_addr = 5'd7;
        @(negedge clk); idle();
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'h1111; b_rd_addr = {5'd7, 5'd7, 5'd7};
        expect_v("nb_busy_no_fwd", 64'h7); expect_v("nb_old_p2", 64'h0);
        expect_v("nb_cnt", 64'h1);
        #1; check_v(64'(b_rd_busy)); check_v(64'(b_rd_data[95:64])); check_v(64'(b_busy_cnt));

        @(negedge clk); idle();
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'h2222; b_rd_addr = {5'd7, 5'd7, 5'd7};
        b_hi_we = 1'b1; b_hi_wdata = 32'hCAFE;
        expect_v("nb_old_p0", 64'h1111); expect_v("nb_old_p1", 64'h1111);
        expect_v("nb_old_p2b", 64'h1111); expect_v("nb_hi_old", 64'h0);
        #1; check_v(64'(b_rd_data[31:0])); check_v(64'(b_rd_data[63:32]));
        check_v(64'(b_rd_data[95:64])); check_v(64'(b_hi));

        @(negedge clk); idle(); b_rd_addr = {5'd0, 5'd3, 5'd7};
        expect_v("nb_new_p0", 64'h2222); expect_v("nb_hi_new", 64'hCAFE);
        expect_v("nb_cnt_after", 64'h0); expect_v("nb_busy_after", 64'h0);
        #1; check_v(64'(b_rd_data[31:0])); check_v(64'(b_hi));
        check_v(64'(b_busy_cnt)); check_v(64'(b_rd_busy));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d unchecked entries, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
